// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: finds 10-bit symbol alignment from control-token runs in blanking,
// then decodes each aligned symbol into pixel byte, control pair and display enable.
module tmds_channel_decoder #(
   parameter int LOCK_TOKENS   = 16,
   parameter int SEARCH_WINDOW = 1024,
   parameter int LOSS_TIMEOUT  = 2048
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [9:0] sym_i,
   input  logic       resync_i,
   output logic [7:0] data_o,
   output logic [1:0] c_o,
   output logic       de_o,
   output logic       locked_o,
   output logic [3:0] offset_o
);

   localparam int RUN_W  = $clog2(LOCK_TOKENS) + 1;
   localparam int WIN_W  = $clog2(SEARCH_WINDOW) + 1;
   localparam int LOSS_W = $clog2(LOSS_TIMEOUT) + 1;

   localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_TOKENS);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
   localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Alignment pipeline
   logic [9:0]  in_q, prev_q, sym_q, sym_d;
   logic [19:0] cat, shifted;
   logic [4:0]  shift_amt;

   // Control state
   state_t              state_q, state_d;
   logic [3:0]          off_q, off_d;
   logic [RUN_W-1:0]    run_q, run_d, run_next;
   logic [WIN_W-1:0]    win_q, win_d;
   logic [LOSS_W-1:0]   loss_q, loss_d;

   // Decode and output stage
   logic       is_tok;
   logic [1:0] tok_c;
   logic [7:0] d_in, dec;
   logic [7:0] data_q, data_d;
   logic [1:0] c_q, c_d;
   logic       de_q, de_d;

   // off=k pulls the k most recent bits of the previous word in as the low bits.
   always_comb begin
      cat       = {in_q, prev_q};
      shift_amt = 5'd10 - {1'b0, off_q};
      shifted   = cat >> shift_amt;
      sym_d     = shifted[9:0];
   end

   always_comb begin
      is_tok = 1'b1;
      tok_c  = 2'b00;
      case (sym_q)
         10'b1101010100: tok_c = 2'b00;
         10'b0010101011: tok_c = 2'b01;
         10'b0101010100: tok_c = 2'b10;
         10'b1010101011: tok_c = 2'b11;
         default:        is_tok = 1'b0;
      endcase
   end

   always_comb begin
      d_in   = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
      dec    = '0;
      dec[0] = d_in[0];
      for (int i = 1; i < 8; i++) begin
         dec[i] = sym_q[8] ? (d_in[i] ^ d_in[i-1]) : ~(d_in[i] ^ d_in[i-1]);
      end
   end

   always_comb begin
      state_d  = state_q;
      off_d    = off_q;
      win_d    = win_q;
      loss_d   = loss_q;
      run_next = is_tok ? ((run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1)) : '0;
      run_d    = run_next;
      case (state_q)
         ST_SEARCH: begin
            win_d = win_q + WIN_W'(1);
            // A completed token run takes priority over slipping the offset.
            if (run_next == RUN_MAX) begin
               state_d = ST_LOCKED;
               win_d   = '0;
               loss_d  = '0;
            end else if (win_q == WIN_LAST) begin
               off_d = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
               win_d = '0;
               run_d = '0;
            end
         end
         ST_LOCKED: begin
            if (is_tok) begin
               loss_d = '0;
            end else if (loss_q == LOSS_LAST) begin
               state_d = ST_SEARCH;
               loss_d  = '0;
               run_d   = '0;
               win_d   = '0;
            end else begin
               loss_d = loss_q + LOSS_W'(1);
            end
         end
         default: state_d = ST_SEARCH;
      endcase
      if (resync_i) begin
         state_d = ST_SEARCH;
         run_d   = '0;
         win_d   = '0;
         loss_d  = '0;
      end
   end

   always_comb begin
      data_d = '0;
      c_d    = '0;
      de_d   = 1'b0;
      if (state_q == ST_LOCKED) begin
         if (is_tok) begin
            c_d = tok_c;
         end else begin
            data_d = dec;
            c_d    = c_q;
            de_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         in_q    <= '0;
         prev_q  <= '0;
         sym_q   <= '0;
         state_q <= ST_SEARCH;
         off_q   <= '0;
         run_q   <= '0;
         win_q   <= '0;
         loss_q  <= '0;
         data_q  <= '0;
         c_q     <= '0;
         de_q    <= 1'b0;
      end else begin
         in_q    <= sym_i;
         prev_q  <= in_q;
         sym_q   <= sym_d;
         state_q <= state_d;
         off_q   <= off_d;
         run_q   <= run_d;
         win_q   <= win_d;
         loss_q  <= loss_d;
         data_q  <= data_d;
         c_q     <= c_d;
         de_q    <= de_d;
      end
   end

   assign data_o   = data_q;
   assign c_o      = c_q;
   assign de_o     = de_q;
   assign locked_o = (state_q == ST_LOCKED);
   assign offset_o = off_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock timing, offset search, full byte decode,
// loss of lock, resync override and asynchronous reset.
module tb_tmds_channel_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] sym_i;
   logic       resync_i;
   logic [7:0] data_o;
   logic [1:0] c_o;
   logic       de_o;
   logic       locked_o;
   logic [3:0] offset_o;

   int tests = 0;
   int fails = 0;

   // Stimulus state: serial rotation, previous symbol, encoder disparity, last control value
   int         rot  = 0;
   logic [9:0] pend = '0;
   int         disp = 0;
   logic [1:0] last_c = 2'b00;

   // {check, de, c[1:0], data[7:0]} per driven symbol
   logic [11:0] exp_q[$];

   tmds_channel_decoder dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .sym_i    (sym_i),
      .resync_i (resync_i),
      .data_o   (data_o),
      .c_o      (c_o),
      .de_o     (de_o),
      .locked_o (locked_o),
      .offset_o (offset_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] tok_word(input logic [1:0] c);
      case (c)
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   // Reference DVI TMDS encoder with running disparity
   function automatic logic [9:0] tmds_enc(input logic [7:0] d);
      logic [8:0] qm;
      logic [9:0] q;
      int n1, n1q, n0q;
      n1    = $countones(d);
      qm    = '0;
      qm[0] = d[0];
      if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
         qm[8] = 1'b1;
      end
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (disp == 0 || n1q == n0q) begin
         q[9]   = ~qm[8];
         q[8]   = qm[8];
         q[7:0] = qm[8] ? qm[7:0] : ~qm[7:0];
         if (qm[8] == 1'b0) disp += n0q - n1q;
         else disp += n1q - n0q;
      end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
         q[9]   = 1'b1;
         q[8]   = qm[8];
         q[7:0] = ~qm[7:0];
         disp  += (qm[8] ? 2 : 0) + n0q - n1q;
      end else begin
         q[9]   = 1'b0;
         q[8]   = qm[8];
         q[7:0] = qm[7:0];
         disp  += (qm[8] ? 0 : -2) + n1q - n0q;
      end
      return q;
   endfunction

   // Drive one symbol (rotated into the serial stream when rot != 0) and score the
   // output that belongs to the symbol driven 2 (aligned) or 3 (rotated) clocks earlier.
   task automatic send_raw(input logic [9:0] s, input logic chk, input logic [7:0] ed,
                           input logic [1:0] ec, input logic ede, input string tag);
      logic [19:0] cat;
      logic [11:0] e;
      int depth;
      if (rot == 0) begin
         sym_i = s;
         depth = 2;
      end else begin
         cat   = {s, pend} >> rot;
         sym_i = cat[9:0];
         depth = 3;
      end
      pend = s;
      exp_q.push_back({chk, ede, ec, ed});
      tick();
      if (exp_q.size() > depth) begin
         e = exp_q.pop_front();
         if (e[11]) check(tag, {21'b0, de_o, c_o, data_o}, {21'b0, e[10:0]});
      end
   endtask

   task automatic send_tok(input logic [1:0] c, input logic chk);
      last_c = c;
      disp   = 0;
      send_raw(tok_word(c), chk, 8'h00, c, 1'b0, "token_out");
   endtask

   task automatic send_byte(input logic [7:0] b, input logic chk, input logic live);
      logic [9:0] w;
      w = tmds_enc(b);
      if (live) send_raw(w, chk, b, last_c, 1'b1, "byte_out");
      else send_raw(w, chk, 8'h00, 2'b00, 1'b0, "byte_out_unlocked");
   endtask

   initial begin
      rst_n    = 1'b0;
      sym_i    = '0;
      resync_i = 1'b0;
      repeat (3) tick();

      check("rst_data",   32'(data_o),   32'h0);
      check("rst_c",      32'(c_o),      32'h0);
      check("rst_de",     32'(de_o),     32'h0);
      check("rst_locked", 32'(locked_o), 32'h0);
      check("rst_offset", 32'(offset_o), 32'h0);
      rst_n = 1'b1;

      // Test 1: aligned token run, lock after 16 tokens plus 2 pipeline stages
      for (int n = 1; n <= 17; n++) send_tok(2'b00, 1'b0);
      check("t1_not_locked_17", 32'(locked_o), 32'h0);
      send_tok(2'b00, 1'b0);
      check("t1_locked_18", 32'(locked_o), 32'h1);
      check("t1_offset", 32'(offset_o), 32'h0);
      for (int n = 19; n <= 100; n++) send_tok(2'b00, 1'b1);
      for (int n = 0; n < 8; n++) send_raw(10'h133, 1'b1, 8'h55, 2'b00, 1'b1, "t1_0x55");
      send_raw(10'h100, 1'b1, 8'h00, 2'b00, 1'b1, "t1_0x00");
      send_raw(10'h200, 1'b1, 8'hff, 2'b00, 1'b1, "t1_0xff");

      // Test 3: every byte through the reference encoder, c holds last token value
      for (int n = 0; n < 4; n++) send_tok(2'b11, 1'b1);
      for (int n = 0; n < 2; n++) send_tok(2'b01, 1'b1);
      for (int n = 0; n < 2; n++) send_tok(2'b10, 1'b1);
      for (int b = 0; b < 256; b++) send_byte(8'(b), 1'b1, 1'b1);
      check("t3_still_locked", 32'(locked_o), 32'h1);

      // Test 4: 2048 non-token symbols drop lock; offset slips 1024 cycles later
      for (int n = 0; n < 20; n++) send_tok(2'b01, 1'b1);
      for (int n = 1; n <= 3074; n++) begin
         send_byte(8'(n * 7), 1'b1, n <= 2048);
         if (n == 2049) check("t4_locked_2049", 32'(locked_o), 32'h1);
         if (n == 2050) check("t4_unlocked_2050", 32'(locked_o), 32'h0);
         if (n == 2051) check("t4_de_low", 32'(de_o), 32'h0);
         if (n == 3073) check("t4_offset_kept", 32'(offset_o), 32'h0);
         if (n == 3074) check("t4_offset_slip", 32'(offset_o), 32'h1);
      end

      // Test 2: stream rotated by 3 bits, search steps through offsets 0..3
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      rot    = 3;
      pend   = '0;
      last_c = 2'b00;
      for (int n = 1; n <= 3100; n++) begin
         send_tok(2'b00, n >= 3095);
         if (n == 1023) check("t2_off0_end", 32'(offset_o), 32'h0);
         if (n == 1024) check("t2_off1", 32'(offset_o), 32'h1);
         if (n == 2047) check("t2_off1_end", 32'(offset_o), 32'h1);
         if (n == 2048) check("t2_off2", 32'(offset_o), 32'h2);
         if (n == 3072) check("t2_off3", 32'(offset_o), 32'h3);
         if (n == 3088) check("t2_not_locked", 32'(locked_o), 32'h0);
         if (n == 3089) check("t2_locked", 32'(locked_o), 32'h1);
      end
      for (int b = 0; b < 64; b++) send_byte(8'(b * 37 + 11), 1'b1, 1'b1);
      check("t2_offset_final", 32'(offset_o), 32'h3);

      // Test 5: resync overrides a coinciding lock condition
      for (int n = 0; n < 4; n++) send_tok(2'b00, 1'b0);
      resync_i = 1'b1;
      send_tok(2'b00, 1'b0);
      resync_i = 1'b0;
      check("t5_resync_drop", 32'(locked_o), 32'h0);
      for (int n = 0; n < 15; n++) send_tok(2'b00, 1'b0);
      resync_i = 1'b1;
      send_tok(2'b00, 1'b0);
      resync_i = 1'b0;
      check("t5_override_lock", 32'(locked_o), 32'h0);
      check("t5_offset_kept", 32'(offset_o), 32'h3);
      for (int n = 0; n < 15; n++) send_tok(2'b00, 1'b0);
      check("t5_not_yet", 32'(locked_o), 32'h0);
      send_tok(2'b00, 1'b0);
      check("t5_relocked", 32'(locked_o), 32'h1);
      check("t5_relock_offset", 32'(offset_o), 32'h3);

      // Test 6: asynchronous reset during active video
      for (int b = 0; b < 6; b++) send_byte(8'(b + 100), 1'b1, 1'b1);
      check("t6_active", 32'(de_o), 32'h1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_async_data",   32'(data_o),   32'h0);
      check("t6_async_c",      32'(c_o),      32'h0);
      check("t6_async_de",     32'(de_o),     32'h0);
      check("t6_async_locked", 32'(locked_o), 32'h0);
      check("t6_async_offset", 32'(offset_o), 32'h0);
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      rot = 0;
      for (int n = 1; n <= 1024; n++) begin
         send_byte(8'(n), 1'b1, 1'b0);
         if (n == 1023) check("t6_restart_off0", 32'(offset_o), 32'h0);
         if (n == 1024) check("t6_restart_off1", 32'(offset_o), 32'h1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
